compare_iter: RTL and testbench

Multi-cycle, parametrised magnitude/equality comparator that evaluates all six RISC-V branch conditions by scanning operands MSB-chunk-first, CHUNK bits per cycle. Sits beside the branch unit and the wide-operand datapaths where a single-cycle WIDTH-bit compare does not close timing. Uses a valid/ready handshake on both sides, a sync flush for mispredict kill, and exposes lt/eq/gt flags alongside the selected result.

---
 rtl/compare_pkg.sv | 29 ++
 rtl/compare_chunk.sv | 16 +
 rtl/compare_iter.sv | 173 +++++++++++++++++
 tb/tb_compare_iter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared types and op-decode helpers for the iterative branch comparator.
package compare_pkg;

    typedef enum logic [2:0] {
        OP_EQ  = 3'b000,
        OP_NE  = 3'b001,
        OP_LT  = 3'b100,
        OP_GE  = 3'b101,
        OP_LTU = 3'b110,
        OP_GEU = 3'b111
    } cmp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } cmp_state_e;

    // Everything except LTU/GEU is treated as signed; the encodings 010/011 are illegal
    // and their signedness is irrelevant because their result is forced to 0.
    function automatic logic is_signed_op(input logic [2:0] op);
        return !(op[2] && op[1]);
    endfunction

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op[2:1] != 2'b01);
    endfunction

endpackage

// File: rtl/compare_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module compare_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             lt_o,
    output logic             eq_o,
    output logic             gt_o
);

    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/compare_iter.sv
// Multi-cycle RISC-V branch-condition comparator, scanning MSB chunk first.
// Optional early termination on the first differing chunk: COMPARE_ITER_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | ready for a request, in_ready high
// BUSY  | scanning one chunk per cycle from the MSB end
// DONE  | result and flags held until out_valid && out_ready
module compare_iter
    import compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_op_i,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_result_o,
    output logic             out_lt_o,
    output logic             out_eq_o,
    output logic             out_gt_o,
    output logic             out_illegal_o
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;

    logic [CHUNK-1:0] a_ch, b_ch;
    logic             ch_lt, ch_eq, ch_gt;
    logic             last_chunk;
    logic             done_now;
    logic [WIDTH-1:0] sign_flip;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    compare_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i  (a_ch),
        .b_i  (b_ch),
        .lt_o (ch_lt),
        .eq_o (ch_eq),
        .gt_o (ch_gt)
    );

    assign last_chunk = (idx_q == '0);

`ifdef COMPARE_ITER_EARLY_EXIT_EN
    assign done_now = last_chunk || !ch_eq;
`else
    assign done_now = last_chunk;
`endif

    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign sign_flip = is_signed_op(in_op_i) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = in_a_i ^ sign_flip;
                    b_d     = in_b_i ^ sign_flip;
                    op_d    = in_op_i;
                    idx_d   = IDX_W'(N - 1);
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Only the first differing chunk decides the ordering.
                if (!ch_eq && eq_q) begin
                    eq_d = 1'b0;
                    lt_d = ch_lt;
                    gt_d = ch_gt;
                end
                idx_d = idx_q - IDX_W'(1);
                if (done_now) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    logic done_st;
    logic result_raw;

    assign done_st = (state_q == ST_DONE);

    always_comb begin
        result_raw = 1'b0;
        case (op_q)
            OP_EQ:          result_raw = eq_q;
            OP_NE:          result_raw = !eq_q;
            OP_LT, OP_LTU:  result_raw = lt_q;
            OP_GE, OP_GEU:  result_raw = !lt_q;
            default:        result_raw = 1'b0;
        endcase
    end

    assign in_ready_o    = (state_q == ST_IDLE);
    assign out_valid_o   = done_st;
    assign out_result_o  = done_st && is_legal_op(op_q) && result_raw;
    assign out_lt_o      = done_st && lt_q;
    assign out_eq_o      = done_st && eq_q;
    assign out_gt_o      = done_st && gt_q;
    assign out_illegal_o = done_st && !is_legal_op(op_q);

endmodule

// File: tb/tb_compare_iter.sv
// Directed self-checking bench for compare_iter (WIDTH=32, CHUNK=8).
module tb_compare_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic        out_result, out_lt, out_eq, out_gt, out_illegal;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int lat;

    always #5 clk = ~clk;

    compare_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_op_i       (in_op),
        .in_a_i        (in_a),
        .in_b_i        (in_b),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_result_o  (out_result),
        .out_lt_o      (out_lt),
        .out_eq_o      (out_eq),
        .out_gt_o      (out_gt),
        .out_illegal_o (out_illegal)
    );

    // Expected latency when the first differing chunk (from the MSB) is k.
    function automatic int exp_lat(input int k);
`ifdef COMPARE_ITER_EARLY_EXIT_EN
        return k;
`else
        return 4;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        chk("in_ready_before_req", in_ready, 1'b1);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_l);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_latency"}, lat, exp_l);
    endtask

    task automatic check_out(input string tag, input logic res, input logic lt,
                             input logic eq, input logic gt, input logic ill);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_flags"}, {out_lt, out_eq, out_gt}, {lt, eq, gt});
        chk({tag, "_illegal"}, out_illegal, ill);
        chk({tag, "_in_ready_done"}, in_ready, 1'b0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 1'b0);
        chk({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        #12;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_outputs", {out_result, out_lt, out_eq, out_gt, out_illegal}, 5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LTU 1 < 0xFFFFFFFF, differs in the top chunk
        send(3'b110, 32'h0000_0001, 32'hFFFF_FFFF);
        wait_done("ltu_small", exp_lat(1));
        check_out("ltu_small", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        handshake("ltu_small");

        // LT -1 < 1 signed
        send(3'b100, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_done("lt_signed", exp_lat(1));
        check_out("lt_signed", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        handshake("lt_signed");

        // Same operands unsigned: 0xFFFFFFFF > 1
        send(3'b110, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_done("ltu_big", exp_lat(1));
        check_out("ltu_big", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        handshake("ltu_big");

        // GE signed: INT_MIN >= INT_MAX is false
        send(3'b101, 32'h8000_0000, 32'h7FFF_FFFF);
        wait_done("ge_minmax", exp_lat(1));
        check_out("ge_minmax", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        handshake("ge_minmax");

        // EQ equal operands, always full scan
        send(3'b000, 32'h1234_5678, 32'h1234_5678);
        wait_done("eq_equal", 4);
        check_out("eq_equal", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        handshake("eq_equal");

        // NE equal operands with out_ready already high
        out_ready = 1'b1;
        send(3'b001, 32'h1234_5678, 32'h1234_5678);
        wait_done("ne_equal", 4);
        chk("ne_equal_result", out_result, 1'b0);
        chk("ne_equal_eq", out_eq, 1'b1);
        @(posedge clk);
        #1;
        chk("ne_early_ready_valid_drop", out_valid, 1'b0);
        chk("ne_early_ready_in_ready", in_ready, 1'b1);
        out_ready = 1'b0;

        // GEU differing only in the last chunk, consumer stalls 3 cycles
        send(3'b111, 32'h1234_5679, 32'h1234_5678);
        wait_done("geu_last", 4);
        check_out("geu_last", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("geu_hold_valid", out_valid, 1'b1);
            chk("geu_hold_result", out_result, 1'b1);
            chk("geu_hold_flags", {out_lt, out_eq, out_gt}, 3'b001);
            chk("geu_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #3;
        chk("geu_in_ready_hs_cycle", in_ready, 1'b0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("geu_valid_drop", out_valid, 1'b0);
        chk("geu_in_ready_after", in_ready, 1'b1);

        // Flush in the second BUSY cycle, with a concurrent in_valid
        send(3'b000, 32'h1234_5678, 32'h1234_5678);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 3'b110;
        @(posedge clk);
        #1;
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("flush_no_accept", in_ready, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_stays_idle_valid", out_valid, 1'b0);
        send(3'b101, 32'd5, 32'd5);
        wait_done("bge_after_flush", 4);
        check_out("bge_after_flush", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        handshake("bge_after_flush");

        // Asynchronous reset in the middle of BUSY
        send(3'b000, 32'h1234_5678, 32'h1234_5678);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_outputs", {out_result, out_lt, out_eq, out_gt, out_illegal}, 5'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(3'b101, 32'd5, 32'd5);
        wait_done("bge_after_rst", 4);
        check_out("bge_after_rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        handshake("bge_after_rst");

        // Illegal funct3 010: scan runs, result forced to 0
        send(3'b010, 32'd3, 32'd7);
        wait_done("illegal", 4);
        check_out("illegal", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        handshake("illegal");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
